mp3_play_ctrl: RTL and testbench
================================

# mp3_play_ctrl

Playback sequencer for the MP3 player. It turns the single-cycle play, next and previous button pulses into a play/pause/stop state and a current track index. It runs the track-load handshake with the decoder. It drives the next/previous highlight flags that the on-screen button overlay uses to frame the pressed button for a fixed hold time.

## Interface
Parameters:
- TRACKS, default 8: number of tracks; valid range 2..256.
- HOLD_CYC, default 50: number of cycles a highlight stays on; also the button lockout window. Valid range is 1 or more.
- TW, default $clog2(TRACKS): track index width; derived, not overridden.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- i_play, in, 1: play/pause press, one-cycle pulse.
- i_next, in, 1: next-track press, one-cycle pulse.
- i_pre, in, 1: previous-track press, one-cycle pulse.
- i_track_end, in, 1: decoder reports that the current track finished; one-cycle pulse.
- i_load_ack, in, 1: decoder accepted the track load.
- o_track, out, TW: current track index.
- o_load_req, out, 1: load request for o_track; level signal, held until acknowledged.
- o_playing, out, 1: high only in PLAY.
- o_hl_next, out, 1: highlight the next button.
- o_hl_pre, out, 1: highlight the previous button.

## Operation
States:
- IDLE: the reset state, stopped.
- LOAD: waiting for i_load_ack.
- PLAY.
- PAUSE.

Register `resume`, 1 bit: records whether LOAD returns to PLAY (1) or PAUSE (0).

Input acceptance:
- A button pulse (i_play, i_next, i_pre) is accepted only if the hold timer is 0 and the state is not LOAD.
- Pulses that are not accepted are dropped, not queued.
- Priority among simultaneous accepted events: i_next > i_pre > i_track_end > i_play. Only one event acts per cycle.
- i_track_end is acted on only in PLAY. It ignores the timer.

Track arithmetic:
- next: track = (track == TRACKS-1) ? 0 : track+1.
- pre: track = (track == 0) ? TRACKS-1 : track-1.

Transitions:
- IDLE:
  - next/pre: update track, stay in IDLE, no load.
  - play: go to LOAD with resume = 1.
- PLAY:
  - play: go to PAUSE.
  - next/pre: update track, go to LOAD with resume = 1.
  - track_end: track+1 with wrap, go to LOAD with resume = 1, no highlight.
- PAUSE:
  - play: go to PLAY.
  - next/pre: update track, go to LOAD with resume = 0.
- LOAD:
  - o_load_req = 1.
  - i_load_ack sampled while o_load_req = 1: go to PLAY if resume = 1, else PAUSE.
  - i_load_ack in any other state is ignored.

Highlight and lockout:
- An accepted i_next or i_pre loads the timer with HOLD_CYC.
- It sets the matching highlight flag and clears the other flag.
- An accepted i_play loads the timer but sets no flag.
- While the timer is nonzero it decrements by 1 per cycle. Both flags clear in the cycle the timer reaches 0.

## Timing
- Reset: state = IDLE, track = 0, resume = 0, timer = 0. All outputs are 0.
- Reset asserted mid-LOAD drops o_load_req immediately (asynchronous); no load is pending after release.
- Accepted event in cycle N:
  - o_track, state, o_load_req, o_playing and the highlight flags all reflect the event at N+1.
  - All outputs are registered.
- o_load_req handshake:
  - Rises at N+1.
  - Stays high until the cycle i_load_ack = 1 is sampled, and falls in the cycle after that.
  - An ack that is already high in the cycle req rises completes the load in that same cycle, so req is high for exactly 1 cycle.
- Highlight duration: a flag is high for exactly HOLD_CYC cycles, N+1 through N+HOLD_CYC.
- The next button press can be accepted at cycle N+HOLD_CYC+1 at the earliest.
- i_track_end in the same cycle as an accepted next: next wins and the track advances by 1, not 2.

## Structure
- Shared package mp3_pkg:
  - state enum (IDLE, LOAD, PLAY, PAUSE);
  - default HOLD_CYC constant;
  - track-wrap increment and decrement functions, so the display and playlist logic reuse them.
- Sub-module mp3_hold_timer:
  - loadable down-counter with inputs load and value;
  - outputs busy (counter nonzero);
  - instantiated once.
- The controller FSM and the track register stay in mp3_play_ctrl.

## Test plan
Default parameters (TRACKS = 8, HOLD_CYC = 50) unless stated.
- Reset, then i_play in IDLE:
  - o_load_req = 1 one cycle later;
  - ack asserted 3 cycles later leads to o_playing = 1 and o_track = 0.
- In PLAY at track 7, pulse i_next:
  - o_track = 0 and o_hl_next = 1 for 50 cycles, o_hl_pre = 0;
  - load issued, return to PLAY after ack.
- In PAUSE at track 0, pulse i_pre:
  - o_track = 7, o_hl_pre = 1;
  - after ack the state is PAUSE (o_playing = 0).
- Pulse i_next, then i_next again 20 cycles later:
  - the second pulse is ignored;
  - the track advances by 1 only;
  - a third pulse at +51 cycles is accepted.
- i_next and i_pre and i_track_end in the same cycle in PLAY at track 3: o_track = 4 and only o_hl_next is set.
- rst_n low during LOAD with ack pending:
  - o_load_req = 0 immediately;
  - after release the state is IDLE, track 0, and an ack pulse has no effect.

Source files
------------

// File: rtl/mp3_pkg.sv
// Shared playback definitions: controller states, default highlight hold time
// and the track-wrap helpers reused by the display and playlist logic.
package mp3_pkg;

    localparam int unsigned HOLD_CYC_DEF = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    // Next track index with wrap from n-1 back to 0.
    function automatic int unsigned trk_inc(input int unsigned trk, input int unsigned n);
        return (trk == n - 32'd1) ? 32'd0 : trk + 32'd1;
    endfunction

    // Previous track index with wrap from 0 up to n-1.
    function automatic int unsigned trk_dec(input int unsigned trk, input int unsigned n);
        return (trk == 32'd0) ? n - 32'd1 : trk - 32'd1;
    endfunction

endpackage

// File: rtl/mp3_hold_timer.sv
// Loadable down-counter used as the button highlight / lockout timer.
// Ports: clk, rst_n (async active-low), load/value (reload), busy (count != 0),
//        done_c (count is 1, so it reaches 0 at the next edge unless reloaded).
module mp3_hold_timer #(
    parameter int unsigned CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          busy,
    output logic          done_c
);

    logic [CW-1:0] count;

    // Reload wins over the decrement; the count parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy   = (count != '0);
    assign done_c = (count == CW'(1)) && !load;

endmodule

// File: rtl/mp3_play_ctrl.sv
// Playback sequencer: turns play/next/previous button pulses into a
// play/pause/stop state and track index, runs the decoder load handshake and
// drives the next/previous button highlight flags.
// Ports: clk, rst_n (async active-low); i_play/i_next/i_pre button pulses;
//        i_track_end, i_load_ack from the decoder; o_track, o_load_req,
//        o_playing, o_hl_next, o_hl_pre (all registered).
module mp3_play_ctrl
    import mp3_pkg::*;
#(
    parameter int unsigned TRACKS   = 8,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
    parameter int unsigned TW       = $clog2(TRACKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_play,
    input  logic          i_next,
    input  logic          i_pre,
    input  logic          i_track_end,
    input  logic          i_load_ack,
    output logic [TW-1:0] o_track,
    output logic          o_load_req,
    output logic          o_playing,
    output logic          o_hl_next,
    output logic          o_hl_pre
);

    localparam int unsigned CW = $clog2(HOLD_CYC + 1);

    state_t state;
    logic   resume;
    logic   busy;
    logic   tmr_done_c;
    logic   btn_ok_c;
    logic   ev_next_c;
    logic   ev_pre_c;
    logic   ev_end_c;
    logic   ev_play_c;
    logic [TW-1:0] trk_inc_c;
    logic [TW-1:0] trk_dec_c;

    // Event decode: one winner per cycle, next > pre > track_end > play.
    always_comb begin
        btn_ok_c  = !busy && (state != LOAD);
        ev_next_c = btn_ok_c && i_next;
        ev_pre_c  = btn_ok_c && i_pre && !i_next;
        ev_end_c  = (state == PLAY) && i_track_end && !ev_next_c && !ev_pre_c;
        ev_play_c = btn_ok_c && i_play && !i_next && !i_pre && !ev_end_c;
        trk_inc_c = TW'(trk_inc(32'(o_track), TRACKS));
        trk_dec_c = TW'(trk_dec(32'(o_track), TRACKS));
    end

    mp3_hold_timer #(
        .CW (CW)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ev_next_c || ev_pre_c || ev_play_c),
        .value  (CW'(HOLD_CYC)),
        .busy   (busy),
        .done_c (tmr_done_c)
    );

    // Controller FSM with the track register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resume     <= 1'b0;
            o_track    <= '0;
            o_load_req <= 1'b0;
            o_playing  <= 1'b0;
            o_hl_next  <= 1'b0;
            o_hl_pre   <= 1'b0;
        end else begin
            // Highlight flags follow the timer; a new press retargets them.
            if (ev_next_c) begin
                o_hl_next <= 1'b1;
                o_hl_pre  <= 1'b0;
            end else if (ev_pre_c) begin
                o_hl_next <= 1'b0;
                o_hl_pre  <= 1'b1;
            end else if (tmr_done_c) begin
                o_hl_next <= 1'b0;
                o_hl_pre  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ev_next_c) begin
                        o_track <= trk_inc_c;
                    end else if (ev_pre_c) begin
                        o_track <= trk_dec_c;
                    end else if (ev_play_c) begin
                        state      <= LOAD;
                        resume     <= 1'b1;
                        o_load_req <= 1'b1;
                    end
                end
                PLAY: begin
                    if (ev_next_c || ev_end_c || ev_pre_c) begin
                        o_track    <= ev_pre_c ? trk_dec_c : trk_inc_c;
                        state      <= LOAD;
                        resume     <= 1'b1;
                        o_load_req <= 1'b1;
                        o_playing  <= 1'b0;
                    end else if (ev_play_c) begin
                        state     <= PAUSE;
                        o_playing <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (ev_next_c || ev_pre_c) begin
                        o_track    <= ev_pre_c ? trk_dec_c : trk_inc_c;
                        state      <= LOAD;
                        resume     <= 1'b0;
                        o_load_req <= 1'b1;
                    end else if (ev_play_c) begin
                        state     <= PLAY;
                        o_playing <= 1'b1;
                    end
                end
                LOAD: begin
                    if (i_load_ack) begin
                        state      <= resume ? PLAY : PAUSE;
                        o_load_req <= 1'b0;
                        o_playing  <= resume;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp3_play_ctrl.sv
// Directed bench for mp3_play_ctrl at TRACKS=8, HOLD_CYC=50.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mp3_play_ctrl;

    localparam int unsigned TRACKS = 8;
    localparam int unsigned HOLD   = 50;
    localparam int unsigned TW     = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_play;
    logic          i_next;
    logic          i_pre;
    logic          i_track_end;
    logic          i_load_ack;
    logic [TW-1:0] o_track;
    logic          o_load_req;
    logic          o_playing;
    logic          o_hl_next;
    logic          o_hl_pre;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    mp3_play_ctrl #(
        .TRACKS   (TRACKS),
        .HOLD_CYC (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_play      (i_play),
        .i_next      (i_next),
        .i_pre       (i_pre),
        .i_track_end (i_track_end),
        .i_load_ack  (i_load_ack),
        .o_track     (o_track),
        .o_load_req  (o_load_req),
        .o_playing   (o_playing),
        .o_hl_next   (o_hl_next),
        .o_hl_pre    (o_hl_pre)
    );

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus only: one press, an immediate ack, then let the lockout expire.
    task automatic press_ack(input logic nx, input logic pr, input logic pl);
        i_next = nx; i_pre = pr; i_play = pl;
        @(negedge clk);
        i_next = 1'b0; i_pre = 1'b0; i_play = 1'b0;
        i_load_ack = 1'b1;
        @(negedge clk);
        i_load_ack = 1'b0;
        wait_cycles(HOLD + 2);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_play = 1'b0; i_next = 1'b0; i_pre = 1'b0;
        i_track_end = 1'b0; i_load_ack = 1'b0;
        wait_cycles(3);
        total++; if (o_track !== 3'd0) $display("FAIL reset_track: got %0d exp 0", o_track); else pass_cnt++;
        total++; if (o_load_req !== 1'b0) $display("FAIL reset_req: got %b exp 0", o_load_req); else pass_cnt++;
        total++; if (o_playing !== 1'b0) $display("FAIL reset_playing: got %b exp 0", o_playing); else pass_cnt++;
        total++; if ({o_hl_next, o_hl_pre} !== 2'b00) $display("FAIL reset_hl: got %b%b exp 00", o_hl_next, o_hl_pre); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_play_load;
        i_play = 1'b1;
        @(negedge clk);
        i_play = 1'b0;
        total++; if (o_load_req !== 1'b1) $display("FAIL play_req_rise: got %b exp 1", o_load_req); else pass_cnt++;
        total++; if (o_playing !== 1'b0) $display("FAIL play_loading: got %b exp 0", o_playing); else pass_cnt++;
        wait_cycles(2);
        total++; if (o_load_req !== 1'b1) $display("FAIL play_req_hold: got %b exp 1", o_load_req); else pass_cnt++;
        i_load_ack = 1'b1;
        @(negedge clk);
        i_load_ack = 1'b0;
        total++; if (o_playing !== 1'b1) $display("FAIL play_after_ack: got %b exp 1", o_playing); else pass_cnt++;
        total++; if (o_load_req !== 1'b0) $display("FAIL play_req_fall: got %b exp 0", o_load_req); else pass_cnt++;
        total++; if (o_track !== 3'd0) $display("FAIL play_track: got %0d exp 0", o_track); else pass_cnt++;
        wait_cycles(HOLD + 2);
    endtask

    // From PLAY at track 0: pre to track 7, then next wraps to 0.
    task automatic test_next_wrap;
        int hl_cnt;
        press_ack(1'b0, 1'b1, 1'b0);
        total++; if (o_track !== 3'd7) $display("FAIL pre_wrap_track: got %0d exp 7", o_track); else pass_cnt++;
        i_next = 1'b1;
        @(negedge clk);
        i_next = 1'b0;
        total++; if (o_track !== 3'd0) $display("FAIL next_wrap_track: got %0d exp 0", o_track); else pass_cnt++;
        total++; if (o_hl_pre !== 1'b0) $display("FAIL next_wrap_hl_pre: got %b exp 0", o_hl_pre); else pass_cnt++;
        total++; if (o_load_req !== 1'b1) $display("FAIL next_wrap_req: got %b exp 1", o_load_req); else pass_cnt++;
        hl_cnt = o_hl_next ? 1 : 0;
        i_load_ack = 1'b1;
        for (int k = 2; k <= 60; k++) begin
            @(negedge clk);
            if (k == 2) begin
                i_load_ack = 1'b0;
                total++; if (o_load_req !== 1'b0) $display("FAIL next_wrap_req_1cyc: got %b exp 0", o_load_req); else pass_cnt++;
                total++; if (o_playing !== 1'b1) $display("FAIL next_wrap_playing: got %b exp 1", o_playing); else pass_cnt++;
            end
            if (o_hl_next) hl_cnt++;
        end
        total++; if (hl_cnt !== 50) $display("FAIL hl_next_duration: got %0d exp 50", hl_cnt); else pass_cnt++;
    endtask

    // PLAY at track 0 -> PAUSE, then pre loads track 7 and returns to PAUSE.
    task automatic test_pause_pre;
        i_play = 1'b1;
        @(negedge clk);
        i_play = 1'b0;
        total++; if (o_playing !== 1'b0) $display("FAIL pause_playing: got %b exp 0", o_playing); else pass_cnt++;
        total++; if (o_load_req !== 1'b0) $display("FAIL pause_req: got %b exp 0", o_load_req); else pass_cnt++;
        wait_cycles(HOLD + 2);
        i_pre = 1'b1;
        @(negedge clk);
        i_pre = 1'b0;
        total++; if (o_track !== 3'd7) $display("FAIL pause_pre_track: got %0d exp 7", o_track); else pass_cnt++;
        total++; if ({o_hl_next, o_hl_pre} !== 2'b01) $display("FAIL pause_pre_hl: got %b%b exp 01", o_hl_next, o_hl_pre); else pass_cnt++;
        total++; if (o_load_req !== 1'b1) $display("FAIL pause_pre_req: got %b exp 1", o_load_req); else pass_cnt++;
        wait_cycles(2);
        i_load_ack = 1'b1;
        @(negedge clk);
        i_load_ack = 1'b0;
        total++; if (o_playing !== 1'b0) $display("FAIL pause_pre_resume: got %b exp 0", o_playing); else pass_cnt++;
        total++; if (o_load_req !== 1'b0) $display("FAIL pause_pre_req_fall: got %b exp 0", o_load_req); else pass_cnt++;
        wait_cycles(HOLD + 2);
        i_play = 1'b1;
        @(negedge clk);
        i_play = 1'b0;
        total++; if (o_playing !== 1'b1) $display("FAIL pause_to_play: got %b exp 1", o_playing); else pass_cnt++;
        wait_cycles(HOLD + 2);
    endtask

    // PLAY at track 7: next at N, ignored retries at N+20 and N+50, accepted at N+51.
    task automatic test_lockout;
        i_next = 1'b1;
        @(negedge clk);
        i_next = 1'b0;
        i_load_ack = 1'b1;
        total++; if (o_track !== 3'd0) $display("FAIL lock_first: got %0d exp 0", o_track); else pass_cnt++;
        @(negedge clk);
        i_load_ack = 1'b0;
        wait_cycles(18);
        i_next = 1'b1;
        @(negedge clk);
        i_next = 1'b0;
        total++; if (o_track !== 3'd0) $display("FAIL lock_plus20: got %0d exp 0", o_track); else pass_cnt++;
        total++; if (o_load_req !== 1'b0) $display("FAIL lock_plus20_req: got %b exp 0", o_load_req); else pass_cnt++;
        wait_cycles(29);
        total++; if (o_hl_next !== 1'b1) $display("FAIL lock_hl_last: got %b exp 1", o_hl_next); else pass_cnt++;
        i_next = 1'b1;
        @(negedge clk);
        total++; if (o_track !== 3'd0) $display("FAIL lock_plus50: got %0d exp 0", o_track); else pass_cnt++;
        total++; if (o_hl_next !== 1'b0) $display("FAIL lock_hl_off: got %b exp 0", o_hl_next); else pass_cnt++;
        @(negedge clk);
        i_next = 1'b0;
        total++; if (o_track !== 3'd1) $display("FAIL lock_plus51: got %0d exp 1", o_track); else pass_cnt++;
        total++; if (o_hl_next !== 1'b1) $display("FAIL lock_plus51_hl: got %b exp 1", o_hl_next); else pass_cnt++;
        i_load_ack = 1'b1;
        @(negedge clk);
        i_load_ack = 1'b0;
        wait_cycles(HOLD + 2);
    endtask

    // PLAY at track 3 with next, pre and track_end together; then track_end under lockout.
    task automatic test_priority;
        press_ack(1'b1, 1'b0, 1'b0);
        press_ack(1'b1, 1'b0, 1'b0);
        i_next = 1'b1; i_pre = 1'b1; i_track_end = 1'b1;
        @(negedge clk);
        i_next = 1'b0; i_pre = 1'b0; i_track_end = 1'b0;
        total++; if (o_track !== 3'd4) $display("FAIL prio_track: got %0d exp 4", o_track); else pass_cnt++;
        total++; if ({o_hl_next, o_hl_pre} !== 2'b10) $display("FAIL prio_hl: got %b%b exp 10", o_hl_next, o_hl_pre); else pass_cnt++;
        total++; if (o_load_req !== 1'b1) $display("FAIL prio_req: got %b exp 1", o_load_req); else pass_cnt++;
        i_load_ack = 1'b1;
        @(negedge clk);
        i_load_ack = 1'b0;
        total++; if (o_playing !== 1'b1) $display("FAIL prio_playing: got %b exp 1", o_playing); else pass_cnt++;
        i_track_end = 1'b1;
        @(negedge clk);
        i_track_end = 1'b0;
        total++; if (o_track !== 3'd5) $display("FAIL tend_track: got %0d exp 5", o_track); else pass_cnt++;
        total++; if (o_load_req !== 1'b1) $display("FAIL tend_req: got %b exp 1", o_load_req); else pass_cnt++;
        total++; if (o_hl_next !== 1'b1) $display("FAIL tend_hl: got %b exp 1", o_hl_next); else pass_cnt++;
        i_load_ack = 1'b1;
        @(negedge clk);
        i_load_ack = 1'b0;
        total++; if (o_playing !== 1'b1) $display("FAIL tend_resume: got %b exp 1", o_playing); else pass_cnt++;
        wait_cycles(HOLD + 2);
    endtask

    task automatic test_reset_mid_load;
        i_next = 1'b1;
        @(negedge clk);
        i_next = 1'b0;
        total++; if (o_load_req !== 1'b1) $display("FAIL rst_load_req: got %b exp 1", o_load_req); else pass_cnt++;
        total++; if (o_track !== 3'd6) $display("FAIL rst_load_track: got %0d exp 6", o_track); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total++; if (o_load_req !== 1'b0) $display("FAIL rst_async_req: got %b exp 0", o_load_req); else pass_cnt++;
        total++; if (o_track !== 3'd0) $display("FAIL rst_async_track: got %0d exp 0", o_track); else pass_cnt++;
        total++; if (o_hl_next !== 1'b0) $display("FAIL rst_async_hl: got %b exp 0", o_hl_next); else pass_cnt++;
        wait_cycles(2);
        rst_n = 1'b1;
        i_load_ack = 1'b1;
        @(negedge clk);
        i_load_ack = 1'b0;
        total++; if (o_playing !== 1'b0) $display("FAIL rst_ack_playing: got %b exp 0", o_playing); else pass_cnt++;
        total++; if (o_load_req !== 1'b0) $display("FAIL rst_ack_req: got %b exp 0", o_load_req); else pass_cnt++;
        total++; if (o_track !== 3'd0) $display("FAIL rst_ack_track: got %0d exp 0", o_track); else pass_cnt++;
        i_play = 1'b1;
        @(negedge clk);
        i_play = 1'b0;
        total++; if (o_load_req !== 1'b1) $display("FAIL rst_idle_play: got %b exp 1", o_load_req); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_play_load;
        test_next_wrap;
        test_pause_pre;
        test_lockout;
        test_priority;
        test_reset_mid_load;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
